// File: rtl/survivor_mem_writer.sv
// survivor_mem_writer
//   Circular survivor-bit memory plus write-side control for the Viterbi
//   decoder. The ACS array delivers one NS-bit survivor vector per trellis
//   step, and this block stores it at wr_ptr. Once D steps are held, every
//   new step launches one traceback: wr_ptr and s_end are published and
//   force_state0 pulses for one cycle. The ACS is stalled until the
//   traceback unit reports tb_done.
//
//   Optional feature macro: SURV_ZERO_TAIL_EN
//     Defined:   an accept with acs_last=1 stores the vector, forces s_end
//                to 0 and launches a (possibly partial) traceback. After
//                tb_done the block restarts filling from empty.
//     Undefined: acs_last is ignored.
//
// Ports
//   clk, rst      clock (rising edge), synchronous active-high reset
//   acs_valid/acs_ready/acs_surv/acs_best_st/acs_last
//                 survivor vector handshake from the ACS array
//   wr_ptr        next write slot (last written = wr_ptr-1 mod D)
//   s_end         traceback start state
//   force_state0  one-cycle traceback launch pulse
//   tb_done       traceback finished
//   tb_time/tb_state -> tb_surv_bit
//                 registered 1-cycle-latency bit read for the traceback unit
module survivor_mem_writer #(
  parameter int K  = 7,
  parameter int M  = K - 1,
  parameter int D  = 40,
  parameter int NS = 1 << M,
  parameter int AW = $clog2(D)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          acs_valid,
  output logic          acs_ready,
  input  logic [NS-1:0] acs_surv,
  input  logic [M-1:0]  acs_best_st,
  input  logic          acs_last,
  output logic [AW-1:0] wr_ptr,
  output logic [M-1:0]  s_end,
  output logic          force_state0,
  input  logic          tb_done,
  input  logic [AW-1:0] tb_time,
  input  logic [M-1:0]  tb_state,
  output logic          tb_surv_bit
);

  localparam int            FW        = $clog2(D + 1);
  localparam logic [AW-1:0] LAST_SLOT = AW'(D - 1);
  localparam logic [FW-1:0] FILL_FULL = FW'(D);
  localparam logic [FW-1:0] FILL_LAST = FW'(D - 1);
  localparam logic [AW:0]   DEPTH     = (AW + 1)'(D);

  typedef enum logic [1:0] {FILL, LAUNCH, WAIT_TB, STREAM} state_t;

  state_t        state;
  logic [FW-1:0] fill;
  logic          zt_pending;
  logic [NS-1:0] mem [D];
  logic          accept;
  logic          tail_now;
  logic          launch_now;

  // Ready is decoded from the state register but also gated by rst, so the
  // ACS sees ready low for every cycle that reset is held.
  assign acs_ready = ~rst & ((state == FILL) | (state == STREAM));
  assign accept    = acs_valid & acs_ready;

`ifdef SURV_ZERO_TAIL_EN
  assign tail_now = accept & acs_last;
`else
  assign tail_now = 1'b0;
  logic unused_acs_last;
  assign unused_acs_last = acs_last;
`endif

  // A launch happens on the accept that makes the memory full, on every
  // accept once streaming, or on a terminating (zero-tail) step.
  assign launch_now = accept & ((state == STREAM) | (fill == FILL_LAST) | tail_now);

  // Write-side bookkeeping and the launch/wait FSM. The pointer, s_end and
  // fill only move on an accept, so they stay frozen while a traceback is
  // outstanding. zt_pending remembers that the traceback in flight ends a
  // terminated block, which sends the FSM back to an empty FILL.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= FILL;
      wr_ptr       <= '0;
      fill         <= '0;
      s_end        <= '0;
      force_state0 <= 1'b0;
      zt_pending   <= 1'b0;
    end else begin
      force_state0 <= 1'b0;
      if (accept) begin
        wr_ptr <= (wr_ptr == LAST_SLOT) ? '0 : wr_ptr + 1'b1;
        fill   <= (fill == FILL_FULL) ? fill : fill + 1'b1;
        s_end  <= tail_now ? '0 : acs_best_st;
      end
      unique case (state)
        FILL, STREAM: begin
          if (launch_now) begin
            state        <= LAUNCH;
            force_state0 <= 1'b1;
            zt_pending   <= tail_now;
          end
        end
        LAUNCH: state <= WAIT_TB;
        WAIT_TB: begin
          if (tb_done) begin
            if (zt_pending) begin
              state      <= FILL;
              fill       <= '0;
              zt_pending <= 1'b0;
            end else begin
              state <= STREAM;
            end
          end
        end
        default: state <= FILL;
      endcase
    end
  end

  // Survivor storage. The array is deliberately not reset; it is never read
  // meaningfully before it has been written.
  always_ff @(posedge clk) begin
    if (accept) begin
      mem[wr_ptr] <= acs_surv;
    end
  end

  // Registered traceback read. Out-of-range slots read as 0. Writes are
  // stalled during a traceback, so a read never races a write to its slot.
  always_ff @(posedge clk) begin
    if (rst) begin
      tb_surv_bit <= 1'b0;
    end else if ({1'b0, tb_time} < DEPTH) begin
      tb_surv_bit <= mem[tb_time][tb_state];
    end else begin
      tb_surv_bit <= 1'b0;
    end
  end

endmodule

// File: tb/tb_survivor_mem_writer.sv
// tb_survivor_mem_writer
//   Self-checking bench for survivor_mem_writer. A behavioural model holds
//   the survivor memory as a plain array, a write counter taken mod D, a
//   saturating fill count and a "traceback outstanding" flag. It predicts
//   the pulse, pointer, start state and read bit for each clock.
module tb_survivor_mem_writer;

  localparam int K  = 7;
  localparam int M  = K - 1;
  localparam int D  = 40;
  localparam int NS = 1 << M;
  localparam int AW = $clog2(D);

  logic          clk = 1'b0;
  logic          rst;
  logic          acs_valid;
  logic          acs_ready;
  logic [NS-1:0] acs_surv;
  logic [M-1:0]  acs_best_st;
  logic          acs_last;
  logic [AW-1:0] wr_ptr;
  logic [M-1:0]  s_end;
  logic          force_state0;
  logic          tb_done;
  logic [AW-1:0] tb_time;
  logic [M-1:0]  tb_state;
  logic          tb_surv_bit;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [NS-1:0] m_mem [D];
  int            m_wr;
  int            m_fill;
  logic [M-1:0]  m_send;
  bit            m_busy;
  bit            m_pulse;
  bit            m_zt;
  logic          m_bit;

  survivor_mem_writer #(.K(K), .D(D)) dut (
    .clk          (clk),
    .rst          (rst),
    .acs_valid    (acs_valid),
    .acs_ready    (acs_ready),
    .acs_surv     (acs_surv),
    .acs_best_st  (acs_best_st),
    .acs_last     (acs_last),
    .wr_ptr       (wr_ptr),
    .s_end        (s_end),
    .force_state0 (force_state0),
    .tb_done      (tb_done),
    .tb_time      (tb_time),
    .tb_state     (tb_state),
    .tb_surv_bit  (tb_surv_bit)
  );

  always #5 clk = ~clk;

  // Safety net so the run always terminates.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Advance one clock and the model in step with it. Acceptance and the
  // expected read bit are decided from the values presented before the
  // edge; outputs are then examined 1 time unit after the edge.
  task automatic tick();
    bit   acc;
    bit   launch;
    logic nb;
    acc = (acs_valid === 1'b1) && !rst && !m_busy;
    nb  = (int'(tb_time) < D) ? m_mem[tb_time][tb_state] : 1'b0;
    @(posedge clk);
    #1;
    if (rst) begin
      m_wr = 0; m_fill = 0; m_send = '0; m_busy = 0; m_pulse = 0; m_zt = 0; m_bit = 1'b0;
    end else begin
      m_bit = nb;
      if (m_busy && !m_pulse && tb_done) begin
        m_busy = 0;
        if (m_zt) begin
          m_fill = 0;
          m_zt   = 0;
        end
      end
      m_pulse = 0;
      if (acc) begin
        m_mem[m_wr] = acs_surv;
        m_send      = acs_best_st;
        m_wr        = (m_wr + 1) % D;
        if (m_fill < D) m_fill++;
        launch = (m_fill == D);
`ifdef SURV_ZERO_TAIL_EN
        if (acs_last) begin
          m_send = '0;
          launch = 1;
          m_zt   = 1;
        end
`endif
        if (launch) begin
          m_pulse = 1;
          m_busy  = 1;
        end
      end
    end
  endtask

  task automatic apply_reset();
    rst = 1'b1; acs_valid = 1'b0; acs_last = 1'b0; tb_done = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic fill_n(input int n, input logic [M-1:0] best);
    for (int i = 0; i < n; i++) begin
      acs_valid   = 1'b1;
      acs_surv    = {$urandom(), $urandom()};
      acs_best_st = best;
      tick();
    end
    acs_valid = 1'b0;
  endtask

  // Reference traceback over the model memory: the predecessor state
  // shifts the decision bit into the low end of the state.
  function automatic int traceback_model(input int start_state, input int start_slot);
    int s = start_state;
    int t = start_slot;
    for (int i = 0; i < D; i++) begin
      s = ((s << 1) | int'(m_mem[t][s])) & (NS - 1);
      t = (t == 0) ? D - 1 : t - 1;
    end
    return s;
  endfunction

  task automatic test_reset();
    rst = 1'b1; acs_valid = 1'b1; acs_surv = {$urandom(), $urandom()};
    acs_best_st = 6'd7; acs_last = 1'b0; tb_done = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (acs_ready !== 1'b0) begin errors++; $display("[TB] FAIL reset_ready: got %b want 0", acs_ready); end
      checks++; if (force_state0 !== 1'b0) begin errors++; $display("[TB] FAIL reset_pulse: got %b want 0", force_state0); end
      checks++; if (wr_ptr !== '0) begin errors++; $display("[TB] FAIL reset_wr_ptr: got %0d want 0", wr_ptr); end
      checks++; if (s_end !== '0) begin errors++; $display("[TB] FAIL reset_s_end: got %0d want 0", s_end); end
      checks++; if (tb_surv_bit !== 1'b0) begin errors++; $display("[TB] FAIL reset_bit: got %b want 0", tb_surv_bit); end
    end
    acs_valid = 1'b0; tb_done = 1'b0; rst = 1'b0;
    #1;
    checks++; if (acs_ready !== 1'b1) begin errors++; $display("[TB] FAIL ready_after_reset: got %b want 1", acs_ready); end
  endtask

  task automatic test_fill_launch();
    apply_reset();
    for (int i = 0; i < D; i++) begin
      acs_valid = 1'b1; acs_surv = {$urandom(), $urandom()}; acs_best_st = 6'd5;
      tick();
      checks++; if (force_state0 !== (i == D - 1)) begin errors++; $display("[TB] FAIL fill_pulse[%0d]: got %b want %b", i, force_state0, (i == D - 1)); end
      checks++; if (wr_ptr !== AW'(m_wr)) begin errors++; $display("[TB] FAIL fill_wr_ptr[%0d]: got %0d want %0d", i, wr_ptr, m_wr); end
    end
    acs_valid = 1'b0;
    checks++; if (wr_ptr !== '0) begin errors++; $display("[TB] FAIL launch_wr_ptr: got %0d want 0", wr_ptr); end
    checks++; if (s_end !== 6'd5) begin errors++; $display("[TB] FAIL launch_s_end: got %0d want 5", s_end); end
    tick();
    checks++; if (force_state0 !== 1'b0) begin errors++; $display("[TB] FAIL pulse_width: got %b want 0", force_state0); end
  endtask

  task automatic test_stall();
    logic [M-1:0] best;
    best = M'($urandom_range(0, NS - 1));
    acs_valid = 1'b1; acs_surv = {$urandom(), $urandom()}; acs_best_st = best;
    for (int i = 0; i < 50; i++) begin
      tick();
      checks++; if (acs_ready !== 1'b0) begin errors++; $display("[TB] FAIL stall_ready[%0d]: got %b want 0", i, acs_ready); end
      checks++; if (wr_ptr !== '0) begin errors++; $display("[TB] FAIL stall_wr_ptr[%0d]: got %0d want 0", i, wr_ptr); end
    end
    acs_valid = 1'b0; tb_done = 1'b1;
    tick();
    tb_done = 1'b0;
    checks++; if (acs_ready !== 1'b1) begin errors++; $display("[TB] FAIL stall_release: got %b want 1", acs_ready); end
    acs_valid = 1'b1;
    tick();
    acs_valid = 1'b0;
    checks++; if (force_state0 !== 1'b1) begin errors++; $display("[TB] FAIL stream_pulse: got %b want 1", force_state0); end
    checks++; if (wr_ptr !== AW'(1)) begin errors++; $display("[TB] FAIL stream_wr_ptr: got %0d want 1", wr_ptr); end
    checks++; if (s_end !== best) begin errors++; $display("[TB] FAIL stream_s_end: got %0d want %0d", s_end, best); end
    tick();
    checks++; if (force_state0 !== 1'b0 || acs_ready !== 1'b0) begin errors++; $display("[TB] FAIL stream_wait: got pulse %b ready %b want 0 0", force_state0, acs_ready); end
  endtask

  task automatic test_read();
    int t;
    int s;
    apply_reset();
    for (int i = 0; i < D; i++) begin
      acs_valid = 1'b1; acs_best_st = 6'd1;
      acs_surv = (i == 3) ? 64'h8000_0000_0000_0001 : {$urandom(), $urandom()};
      tick();
    end
    acs_valid = 1'b0;
    tb_time = AW'(3); tb_state = 6'd0; tick();
    checks++; if (tb_surv_bit !== 1'b1) begin errors++; $display("[TB] FAIL read_3_0: got %b want 1", tb_surv_bit); end
    tb_state = 6'd63; tick();
    checks++; if (tb_surv_bit !== 1'b1) begin errors++; $display("[TB] FAIL read_3_63: got %b want 1", tb_surv_bit); end
    tb_state = 6'd1; tick();
    checks++; if (tb_surv_bit !== 1'b0) begin errors++; $display("[TB] FAIL read_3_1: got %b want 0", tb_surv_bit); end
    tb_time = AW'(D + 5); tb_state = 6'd0; tick();
    checks++; if (tb_surv_bit !== 1'b0) begin errors++; $display("[TB] FAIL read_out_of_range: got %b want 0", tb_surv_bit); end
    for (int i = 0; i < 24; i++) begin
      t = $urandom_range(0, D - 1);
      s = $urandom_range(0, NS - 1);
      tb_time = AW'(t); tb_state = M'(s);
      tick();
      checks++; if (tb_surv_bit !== m_bit) begin errors++; $display("[TB] FAIL read_rand[%0d][%0d]: got %b want %b", t, s, tb_surv_bit, m_bit); end
    end
  endtask

  task automatic test_wrap_stream();
    int pulses;
    int wraps;
    int exp_wraps;
    int dut_s;
    int dut_t;
    int mdl_s;
    int prev_ptr;
    apply_reset();
    fill_n(D, M'($urandom_range(0, NS - 1)));
    pulses = (force_state0 === 1'b1) ? 1 : 0;
    wraps = 0;
    exp_wraps = 0;
    for (int k = 1; k <= 100; k++) if (((D + k) % D) == 0) exp_wraps++;
    for (int step = 0; step < 100; step++) begin
      mdl_s = traceback_model(int'(m_send), (m_wr + D - 1) % D);
      dut_s = int'(s_end);
      dut_t = (wr_ptr == '0) ? D - 1 : int'(wr_ptr) - 1;
      for (int i = 0; i < D; i++) begin
        tb_time = AW'(dut_t); tb_state = M'(dut_s);
        tick();
        if (force_state0 === 1'b1) pulses++;
        dut_s = ((dut_s << 1) | ((tb_surv_bit === 1'b1) ? 1 : 0)) & (NS - 1);
        dut_t = (dut_t == 0) ? D - 1 : dut_t - 1;
      end
      checks++; if (pulses != 1) begin errors++; $display("[TB] FAIL step_pulses[%0d]: got %0d want 1", step, pulses); end
      checks++; if (dut_s != mdl_s) begin errors++; $display("[TB] FAIL decode[%0d]: got %0d want %0d", step, dut_s, mdl_s); end
      tb_done = 1'b1; tick(); tb_done = 1'b0;
      checks++; if (acs_ready !== 1'b1) begin errors++; $display("[TB] FAIL step_ready[%0d]: got %b want 1", step, acs_ready); end
      prev_ptr = int'(wr_ptr);
      acs_valid = 1'b1; acs_surv = {$urandom(), $urandom()}; acs_best_st = M'($urandom_range(0, NS - 1));
      tick();
      acs_valid = 1'b0;
      if (prev_ptr == D - 1 && wr_ptr === '0) wraps++;
      pulses = (force_state0 === 1'b1) ? 1 : 0;
      checks++; if (wr_ptr !== AW'(m_wr) || s_end !== m_send) begin errors++; $display("[TB] FAIL step_ptr[%0d]: got %0d/%0d want %0d/%0d", step, wr_ptr, s_end, m_wr, m_send); end
    end
    checks++; if (pulses != 1) begin errors++; $display("[TB] FAIL last_pulse: got %0d want 1", pulses); end
    checks++; if (wraps != exp_wraps) begin errors++; $display("[TB] FAIL wrap_count: got %0d want %0d", wraps, exp_wraps); end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    fill_n(D, 6'd5);
    checks++; if (force_state0 !== 1'b1) begin errors++; $display("[TB] FAIL mid_launch_pulse: got %b want 1", force_state0); end
    rst = 1'b1; tick(); rst = 1'b0;
    checks++; if (force_state0 !== 1'b0 || wr_ptr !== '0) begin errors++; $display("[TB] FAIL rst_in_launch: got pulse %b ptr %0d want 0 0", force_state0, wr_ptr); end
    fill_n(D, 6'd5);
    tick();
    tick();
    rst = 1'b1; tick();
    checks++; if (force_state0 !== 1'b0 || acs_ready !== 1'b0) begin errors++; $display("[TB] FAIL rst_in_wait: got pulse %b ready %b want 0 0", force_state0, acs_ready); end
    rst = 1'b0;
    #1;
    checks++; if (acs_ready !== 1'b1) begin errors++; $display("[TB] FAIL rst_wait_ready: got %b want 1", acs_ready); end
    for (int i = 0; i < D; i++) begin
      acs_valid = 1'b1; acs_surv = {$urandom(), $urandom()}; acs_best_st = 6'd2;
      tick();
      checks++; if (force_state0 !== (i == D - 1)) begin errors++; $display("[TB] FAIL refill_pulse[%0d]: got %b want %b", i, force_state0, (i == D - 1)); end
    end
    acs_valid = 1'b0;
  endtask

  task automatic test_zero_tail();
    apply_reset();
    for (int i = 0; i < 10; i++) begin
      acs_valid = 1'b1; acs_surv = {$urandom(), $urandom()};
      acs_last = (i == 9); acs_best_st = (i == 9) ? 6'd9 : 6'd3;
      tick();
      if (i < 9) begin
        checks++; if (force_state0 !== 1'b0) begin errors++; $display("[TB] FAIL tail_early_pulse[%0d]: got %b want 0", i, force_state0); end
      end
    end
    acs_valid = 1'b0; acs_last = 1'b0;
    checks++; if (wr_ptr !== AW'(10)) begin errors++; $display("[TB] FAIL tail_wr_ptr: got %0d want 10", wr_ptr); end
`ifdef SURV_ZERO_TAIL_EN
    checks++; if (force_state0 !== 1'b1) begin errors++; $display("[TB] FAIL tail_pulse: got %b want 1", force_state0); end
    checks++; if (s_end !== '0) begin errors++; $display("[TB] FAIL tail_s_end: got %0d want 0", s_end); end
    tick();
    tb_done = 1'b1; tick(); tb_done = 1'b0;
    checks++; if (acs_ready !== 1'b1) begin errors++; $display("[TB] FAIL tail_back_to_fill: got %b want 1", acs_ready); end
    for (int i = 0; i < D; i++) begin
      acs_valid = 1'b1; acs_surv = {$urandom(), $urandom()}; acs_best_st = 6'd4;
      tick();
      checks++; if (force_state0 !== (i == D - 1)) begin errors++; $display("[TB] FAIL tail_refill[%0d]: got %b want %b", i, force_state0, (i == D - 1)); end
    end
    acs_valid = 1'b0;
`else
    checks++; if (force_state0 !== 1'b0) begin errors++; $display("[TB] FAIL last_ignored_pulse: got %b want 0", force_state0); end
    checks++; if (s_end !== 6'd9) begin errors++; $display("[TB] FAIL last_ignored_s_end: got %0d want 9", s_end); end
    checks++; if (acs_ready !== 1'b1) begin errors++; $display("[TB] FAIL last_ignored_ready: got %b want 1", acs_ready); end
`endif
    checks++; if (s_end !== m_send) begin errors++; $display("[TB] FAIL tail_model_s_end: got %0d want %0d", s_end, m_send); end
  endtask

  initial begin
    rst = 1'b1; acs_valid = 1'b0; acs_surv = '0; acs_best_st = '0; acs_last = 1'b0;
    tb_done = 1'b0; tb_time = '0; tb_state = '0;
    m_wr = 0; m_fill = 0; m_send = '0; m_busy = 0; m_pulse = 0; m_zt = 0; m_bit = 1'b0;
    test_reset();
    test_fill_launch();
    test_stall();
    test_read();
    test_wrap_stream();
    test_reset_mid();
    test_zero_tail();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
